// File: rtl/arb_rr_n_if.sv
// Client request/return and memory port bundle for arb_rr_n.
// slave is the arbiter side; master is the clients plus memory.
interface arb_rr_n_if #(
    parameter int N  = 4,
    parameter int W  = 16,
    parameter int AW = 10
);
    logic [N-1:0]    client_req;
    logic [N-1:0]    client_read;
    logic [N*AW-1:0] client_addr;
    logic [N*W-1:0]  client_wdata;
    logic [N-1:0]    client_gnt;
    logic [N-1:0]    client_rvalid;
    logic [W-1:0]    client_rdata;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [W-1:0]    mem_wdata;
    logic [W-1:0]    mem_rdata;

    modport slave (
        input  client_req,
        input  client_read,
        input  client_addr,
        input  client_wdata,
        input  mem_rdata,
        output client_gnt,
        output client_rvalid,
        output client_rdata,
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport master (
        output client_req,
        output client_read,
        output client_addr,
        output client_wdata,
        output mem_rdata,
        input  client_gnt,
        input  client_rvalid,
        input  client_rdata,
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/arb_rr_n.sv
// N-client round-robin arbiter onto a single-port data memory,
// with burst grant-lock and tagged in-order read return.
module arb_rr_n #(
    parameter int N       = 4,
    parameter int W       = 16,
    parameter int AW      = 10,
    parameter int BURST   = 1,
    parameter int MEM_LAT = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    arb_rr_n_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = $clog2(BURST + 1);
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [RW-1:0] RMAX = RW'(BURST);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    typedef struct packed {
        logic          vld;
        logic [IW-1:0] idx;
    } ret_t;

    state_t        state_q;
    state_t        state_d;
    logic [IW-1:0] owner_q;
    logic [IW-1:0] owner_d;
    logic [RW-1:0] run_q;
    logic [RW-1:0] run_d;

    logic          keep;
    logic          hit;
    logic [IW-1:0] hit_idx;
    logic          gnt_any;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] mem_idx;
    ret_t          pipe_q [MEM_LAT];
    ret_t          tail;

    function automatic logic [IW-1:0] wrap(
        input logic [IW-1:0] base,
        input int            k
    );
        int s;
        s = int'(base) + k;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    assign keep = (state_q == OWN)
               && bus.client_req[owner_q]
               && (run_q < RMAX);

    // Walk from owner+N down to owner+1 so the nearest requester wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = owner_q;
        for (int k = N; k >= 1; k--) begin
            if (bus.client_req[wrap(owner_q, k)]) begin
                hit     = 1'b1;
                hit_idx = wrap(owner_q, k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        run_d   = run_q;
        gnt_any = 1'b0;
        gnt_idx = owner_q;
        unique case (1'b1)
            keep: begin
                gnt_any = 1'b1;
                run_d   = run_q + 1'b1;
                state_d = OWN;
            end
            hit && !keep: begin
                gnt_any = 1'b1;
                gnt_idx = hit_idx;
                owner_d = hit_idx;
                run_d   = RW'(1);
                state_d = OWN;
            end
            default: begin
                run_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= LAST;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        bus.client_gnt = '0;
        if (gnt_any && rst_n) begin
            bus.client_gnt[gnt_idx] = 1'b1;
        end
    end

    // Address and data hold their last value when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            mem_idx       <= '0;
        end else begin
            bus.mem_en <= gnt_any;
            bus.mem_we <= gnt_any
                        & ~bus.client_read[gnt_idx];
            if (gnt_any) begin
                bus.mem_addr  <=
                    bus.client_addr[gnt_idx*AW +: AW];
                bus.mem_wdata <=
                    bus.client_wdata[gnt_idx*W +: W];
                mem_idx       <= gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= {bus.mem_en & ~bus.mem_we,
                          mem_idx};
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tail = pipe_q[MEM_LAT-1];

    always_comb begin
        bus.client_rvalid = '0;
        bus.client_rdata  = '0;
        if (tail.vld) begin
            bus.client_rvalid[tail.idx] = 1'b1;
            bus.client_rdata            = bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_arb_rr_n.sv
// Scoreboard bench for arb_rr_n: three configurations
// driven by directed vectors plus a random traffic run.
module tb_arb_rr_n;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_run = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int cyc;
        int idx;
    } gnt_e;

    typedef struct packed {
        int          cyc;
        logic        we;
        logic [9:0]  addr;
        logic [15:0] wd;
    } mem_e;

    typedef struct packed {
        int          cyc;
        int          idx;
        logic [15:0] data;
    } ret_e;

    gnt_e gqa[$];
    gnt_e gqb[$];
    mem_e aqa[$];
    ret_e rqa[$];
    ret_e rqb[$];
    ret_e rqc[$];

    arb_rr_n_if #(.N(4), .W(16), .AW(10)) bus_a ();
    arb_rr_n_if #(.N(4), .W(16), .AW(10)) bus_b ();
    arb_rr_n_if #(.N(5), .W(16), .AW(10)) bus_c ();

    arb_rr_n #(
        .N(4), .W(16), .AW(10), .BURST(1), .MEM_LAT(2)
    ) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

    arb_rr_n #(
        .N(4), .W(16), .AW(10), .BURST(3), .MEM_LAT(3)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    arb_rr_n #(
        .N(5), .W(16), .AW(10), .BURST(2), .MEM_LAT(1)
    ) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    task automatic chk(
        input string       name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h",
                     name, act, exp);
        end
    endtask

    // Memory A: two-cycle read latency, preloaded in reset.
    logic [15:0] mem_a [1024];
    logic [15:0] pa0;
    logic [15:0] pa1;
    assign bus_a.mem_rdata = pa1;
    always @(posedge clk) begin
        if (!rst_n) begin
            mem_a[5]  <= 16'hBEEF;
            mem_a[10] <= 16'h1234;
        end else if (bus_a.mem_en && bus_a.mem_we) begin
            mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
        end
        pa0 <= mem_a[bus_a.mem_addr];
        pa1 <= pa0;
    end

    assign bus_b.mem_rdata = 16'hD00D;

    // Memory C: one-cycle read latency, cleared in reset.
    logic [15:0] mem_c [8];
    logic [15:0] pc0;
    assign bus_c.mem_rdata = pc0;
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) mem_c[i] <= '0;
        end else if (bus_c.mem_en && bus_c.mem_we) begin
            mem_c[bus_c.mem_addr[2:0]] <= bus_c.mem_wdata;
        end
        pc0 <= mem_c[bus_c.mem_addr[2:0]];
    end

    always @(negedge clk) begin
        if (bus_a.client_gnt != 0) begin
            if (gqa.size() == 0) begin
                chk("a_gnt_extra", 32'(bus_a.client_gnt), 0);
            end else begin
                gnt_e e;
                e = gqa.pop_front();
                chk("a_gnt", 32'(bus_a.client_gnt), 1 << e.idx);
                chk("a_gnt_cyc", cyc, e.cyc);
            end
        end
        if (bus_a.mem_en) begin
            if (aqa.size() == 0) begin
                chk("a_mem_extra", 32'(bus_a.mem_en), 0);
            end else begin
                mem_e m;
                m = aqa.pop_front();
                chk("a_mem_cyc", cyc, m.cyc);
                chk("a_mem_we", 32'(bus_a.mem_we), 32'(m.we));
                chk("a_mem_addr", 32'(bus_a.mem_addr), 32'(m.addr));
                if (m.we) chk("a_mem_wdata", 32'(bus_a.mem_wdata), 32'(m.wd));
            end
        end
        if (bus_a.client_rvalid != 0) begin
            if (rqa.size() == 0) begin
                chk("a_rv_extra", 32'(bus_a.client_rvalid), 0);
            end else begin
                ret_e r;
                r = rqa.pop_front();
                chk("a_rv", 32'(bus_a.client_rvalid), 1 << r.idx);
                chk("a_rv_cyc", cyc, r.cyc);
                chk("a_rdata", 32'(bus_a.client_rdata), 32'(r.data));
            end
        end
    end

    always @(negedge clk) begin
        if (bus_b.client_gnt != 0) begin
            if (gqb.size() == 0) begin
                chk("b_gnt_extra", 32'(bus_b.client_gnt), 0);
            end else begin
                gnt_e e;
                e = gqb.pop_front();
                chk("b_gnt", 32'(bus_b.client_gnt), 1 << e.idx);
                chk("b_gnt_cyc", cyc, e.cyc);
            end
        end
        if (bus_b.client_rvalid != 0) begin
            if (rqb.size() == 0) begin
                chk("b_rv_extra", 32'(bus_b.client_rvalid), 0);
            end else begin
                ret_e r;
                r = rqb.pop_front();
                chk("b_rv", 32'(bus_b.client_rvalid), 1 << r.idx);
                chk("b_rv_cyc", cyc, r.cyc);
            end
        end
    end

    int wc [5] = '{0, 0, 0, 0, 0};
    always @(negedge clk) begin
        chk("c_onehot", 32'($onehot0(bus_c.client_gnt)), 1);
        for (int i = 0; i < 5; i++) begin
            if (bus_c.client_gnt[i]) begin
                n_run++;
                if (wc[i] > 8) begin
                    n_fail++;
                    $display("FAIL c_wait client %0d: waited %0d, limit 8",
                             i, wc[i]);
                end
                wc[i] = 0;
            end else if (bus_c.client_req[i]) begin
                wc[i]++;
            end
        end
        if (bus_c.client_rvalid != 0) begin
            if (rqc.size() == 0) begin
                chk("c_rv_extra", 32'(bus_c.client_rvalid), 0);
            end else begin
                ret_e r;
                r = rqc.pop_front();
                chk("c_rv", 32'(bus_c.client_rvalid), 1 << r.idx);
                chk("c_rv_cyc", cyc, r.cyc);
                chk("c_rdata", 32'(bus_c.client_rdata), 32'(r.data));
            end
        end
    end

    task automatic a_step(
        input logic [3:0]  req,
        input logic [3:0]  rd,
        input logic [39:0] ad,
        input logic [63:0] wd,
        input int          g,
        input logic [15:0] rdat
    );
        @(posedge clk);
        #1;
        bus_a.client_req   = req;
        bus_a.client_read  = rd;
        bus_a.client_addr  = ad;
        bus_a.client_wdata = wd;
        if (g >= 0) begin
            gqa.push_back('{cyc, g});
            aqa.push_back('{cyc + 1, ~rd[g],
                            ad[g*10 +: 10], wd[g*16 +: 16]});
            if (rd[g]) rqa.push_back('{cyc + 3, g, rdat});
        end
    endtask

    task automatic b_step(
        input logic [3:0] req,
        input logic [3:0] rd,
        input int         g
    );
        @(posedge clk);
        #1;
        bus_b.client_req  = req;
        bus_b.client_read = rd;
        if (g >= 0) begin
            gqb.push_back('{cyc, g});
            if (rd[g]) rqb.push_back('{cyc + 4, g, 16'hD00D});
        end
    endtask

    logic [15:0] sh [8];

    task automatic c_run(input int ncyc);
        logic [4:0]  rq;
        logic [4:0]  rd;
        logic [49:0] ad;
        logic [79:0] wd;
        rq = '0;
        rd = '0;
        ad = '0;
        wd = '0;
        for (int i = 0; i < 8; i++) sh[i] = '0;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            for (int i = 0; i < 5; i++) begin
                if (bus_c.client_gnt[i]) begin
                    logic [2:0] a;
                    a = ad[i*10 +: 3];
                    if (rd[i]) rqc.push_back('{cyc + 2, i, sh[a]});
                    else sh[a] = wd[i*16 +: 16];
                end
            end
            for (int i = 0; i < 5; i++) begin
                if (!rq[i] || bus_c.client_gnt[i]) begin
                    rq[i] = ($urandom_range(0, 99) < 70);
                    rd[i] = 1'($urandom_range(0, 1));
                    ad[i*10 +: 10] = 10'($urandom_range(0, 7));
                    wd[i*16 +: 16] = 16'($urandom);
                end
            end
            @(posedge clk);
            #1;
            bus_c.client_req   = rq;
            bus_c.client_read  = rd;
            bus_c.client_addr  = ad;
            bus_c.client_wdata = wd;
        end
        bus_c.client_req = '0;
    endtask

    localparam logic [39:0] AD_RR = {10'h013, 10'h012, 10'h011, 10'h010};
    localparam logic [63:0] WD_RR = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    localparam int          BURST_G [10] = '{1, 1, 1, 2, 2, 2, 1, 1, 1, 2};

    initial begin
        rst_n = 1'b0;
        bus_a.client_req   = '0;
        bus_a.client_read  = '0;
        bus_a.client_addr  = '0;
        bus_a.client_wdata = '0;
        bus_b.client_req   = 4'hF;
        bus_b.client_read  = '0;
        bus_b.client_addr  = {10'h3C3, 10'h2B2, 10'h1A1, 10'h091};
        bus_b.client_wdata = {16'hB003, 16'hB002, 16'hB001, 16'hB000};
        bus_c.client_req   = '0;
        bus_c.client_read  = '0;
        bus_c.client_addr  = '0;
        bus_c.client_wdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt_b", 32'(bus_b.client_gnt), 0);
        chk("rst_mem_en_a", 32'(bus_a.mem_en), 0);
        chk("rst_mem_we_a", 32'(bus_a.mem_we), 0);
        chk("rst_mem_addr_a", 32'(bus_a.mem_addr), 0);
        chk("rst_mem_wdata_a", 32'(bus_a.mem_wdata), 0);
        chk("rst_rvalid_a", 32'(bus_a.client_rvalid), 0);
        bus_b.client_req = '0;
        rst_n = 1'b1;

        // Pure round robin, all clients writing every cycle.
        for (int i = 0; i < 8; i++) begin
            a_step(4'hF, 4'h0, AD_RR, WD_RR, i % 4, 16'h0);
        end
        a_step(4'h0, 4'h0, AD_RR, WD_RR, -1, 16'h0);

        // Two reads back to back, then two writes.
        a_step(4'b1000, 4'b1000, {10'h005, 30'h0}, 64'h0, 3, 16'hBEEF);
        a_step(4'b0001, 4'b0001, {30'h0, 10'h00A}, 64'h0, 0, 16'h1234);
        a_step(4'b0010, 4'b0000, {20'h0, 10'h020, 10'h0},
               {32'h0, 16'h7777, 16'h0}, 1, 16'h0);
        a_step(4'b0100, 4'b0000, {10'h0, 10'h021, 20'h0},
               {16'h0, 16'h5555, 32'h0}, 2, 16'h0);
        repeat (4) a_step(4'h0, 4'h0, 40'h0, 64'h0, -1, 16'h0);

        // Burst lock with two persistent requesters.
        for (int i = 0; i < 10; i++) begin
            b_step(4'b0110, 4'b0000, BURST_G[i]);
        end
        b_step(4'b0000, 4'b0000, -1);

        // Owner drops while 0 and 3 raise.
        b_step(4'b0100, 4'b0000, 2);
        b_step(4'b0100, 4'b0000, 2);
        b_step(4'b1001, 4'b0000, 3);
        b_step(4'b0001, 4'b0000, 0);
        b_step(4'b0000, 4'b0000, -1);

        // Reset with two reads in flight.
        b_step(4'b0010, 4'b0010, 1);
        b_step(4'b0100, 4'b0100, 2);
        @(posedge clk);
        #1;
        bus_b.client_req  = 4'b1001;
        bus_b.client_read = 4'b0000;
        rst_n = 1'b0;
        #1;
        rqb.delete();
        chk("mid_rst_gnt", 32'(bus_b.client_gnt), 0);
        chk("mid_rst_rvalid", 32'(bus_b.client_rvalid), 0);
        chk("mid_rst_rdata", 32'(bus_b.client_rdata), 0);
        chk("mid_rst_mem_en", 32'(bus_b.mem_en), 0);
        chk("mid_rst_mem_we", 32'(bus_b.mem_we), 0);
        chk("mid_rst_mem_addr", 32'(bus_b.mem_addr), 0);
        chk("mid_rst_mem_wdata", 32'(bus_b.mem_wdata), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        gqb.push_back('{cyc, 0});
        @(posedge clk);
        #1;
        bus_b.client_req = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_rvalid", 32'(bus_b.client_rvalid), 0);
        end

        c_run(1000);
        repeat (10) @(posedge clk);
        #1;
        chk("a_queues_left", gqa.size() + aqa.size() + rqa.size(), 0);
        chk("b_queues_left", gqb.size() + rqb.size(), 0);
        chk("c_queue_left", rqc.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/arb_rr_n.md
# arb_rr_n

N-client round-robin arbiter for the shared single-port data memory, the parametrised successor to the two-client `arb_rr_2`. Each client (typically a `setmi` stream endpoint) presents read or write requests; the block grants one per cycle, registers the winning access onto the memory port, and routes read data back to the issuing client after the memory latency. Beyond `arb_rr_2`, it adds a configurable client count, optional burst grant-lock, and tagged read-return routing for memories with latency greater than one.

## Interface
Parameters:
- N, 4: number of clients, 2..16
- W, 16: data width
- AW, 10: address width
- BURST, 1: max consecutive grants to one client before forced rotation, 1..15 (1 = pure round robin)
- MEM_LAT, 1: cycles from registered mem_en (read) to valid mem_rdata, 1..4

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- client_req  in  N  access request per client
- client_read  in  N  1 = read, 0 = write, per client
- client_addr  in  N*AW  flattened addresses, client i at [i*AW +: AW]
- client_wdata  in  N*W  flattened write data
- client_gnt  out  N  one-hot accept, same cycle as request
- client_rvalid  out  N  one-hot read-return strobe
- client_rdata  out  W  read data shared by all clients, qualified by client_rvalid
- mem_en  out  1  memory access strobe
- mem_we  out  1  write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  W  memory write data
- mem_rdata  in  W  memory read data

## Operation
- State: `owner` (last-granted index, log2(N) bits), `run` (consecutive-grant count, width clog2(BURST+1)), `own_vld`.
- IDLE (own_vld=0) or OWN(owner, run). Reset puts the block in IDLE with owner=N-1, so client 0 has first priority.
- Arbitration is combinational on client_req and the registered state:
  - In OWN, if client_req[owner]=1 and run<BURST, grant owner again; run++.
  - Otherwise, grant the first requesting client in circular order owner+1, owner+2, ..., owner. On a change of client, run=1.
  - If no client requests, there is no grant, own_vld becomes 0, and owner is kept.
- client_gnt is at most one-hot and is forced to 0 while rst_n=0. A granted request is consumed: the client presents its next request or drops req in the following cycle.
- Memory port is registered. On a grant: mem_en=1, mem_we=~client_read[g], mem_addr/mem_wdata = slice g. With no grant: mem_en=0, mem_we=0, and addr/wdata hold their values.
- Read return uses a MEM_LAT-deep shift register of {valid, index}, loaded with {mem_en & ~mem_we, registered index}. At the tail, client_rvalid[index]=1 and client_rdata=mem_rdata (combinational pass-through). Writes generate no return.
- Reads and writes issue in grant order. Returns are in order, one per cycle maximum.

## Timing
- Grant latency 0 (same cycle). mem_* is valid the cycle after the grant.
- Read: the grant in cycle t gives mem_en in t+1 and client_rvalid/client_rdata in t+1+MEM_LAT.
- Throughput is one access per cycle, back-to-back, including across client switches with no bubble.
- Starvation bound: a continuously requesting client is granted within (N-1)*BURST cycles.
- Simultaneous events:
  - Owner drops req while others request: next grant searches from owner+1 in the same cycle.
  - Sole requester at run=BURST: regranted, with run reset to 1.
- Reset values: client_gnt=0, client_rvalid=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, owner=N-1, run=0, shift register cleared.
- Asynchronous reset mid-operation discards in-flight reads; no client_rvalid is produced for them after release.

## Test plan
- N=4, BURST=1, all clients write continuously from the first cycle after reset: grants go 0,1,2,3,0,… one per cycle; mem_addr sequence matches the client slices one cycle later.
- N=4, BURST=3, clients 1 and 2 always requesting: grants go 1,1,1,2,2,2,1,…; client 2 waits no more than 3 cycles.
- MEM_LAT=2, client 3 reads addr 0x05, client 0 reads addr 0x0A in consecutive cycles, memory model preloaded: client_rvalid[3] at t+3 with mem[5], then client_rvalid[0] at t+4 with mem[0xA]; no rvalid for interleaved writes.
- Owner 2 drops req in the same cycle that clients 0 and 3 raise req: client 3 is granted that cycle, then client 0.
- Assert rst_n=0 with two reads in flight (MEM_LAT=3): all outputs are 0 immediately; no client_rvalid in the 5 cycles after release; first grant after release goes to client 0.
- Random req/read/addr for 1000 cycles, N=5, BURST=2, against a scoreboard memory: every read returns the last written value for its address, client_gnt is never multi-hot, and no client waits more than 8 cycles.
